// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB op sequencer: FSM state enum, default widths, ALU opcodes.
package apb_ctrl_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 8;

  // Opcodes that decode maps onto apb_op with apb_wr = 0 / 1.
  localparam logic [2:0] ALU_OP_LW = 3'b101;
  localparam logic [2:0] ALU_OP_SW = 3'b110;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    DONE   = 2'd3
  } apb_state_t;

endpackage

// File: rtl/apb_timeout_cnt.sv
// ACCESS wait counter: cleared on entry, counts pready=0 cycles, flags the cycle that hits LIMIT waits.
module apb_timeout_cnt #(
  parameter int unsigned LIMIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [7:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + 8'd1;
    end
  end

  // The wait cycle that would bring the count to LIMIT ends the transfer.
  assign expired = inc && (cnt == 8'(LIMIT - 1));

endmodule

// File: rtl/apb_op_ctrl.sv
// Sequences one APB3 transfer per apb_op instruction, stalling the pipeline until it retires.
// Optional ACCESS timeout under `APB_TIMEOUT_EN; min latency 3 cycles, done on the 4th.
import apb_ctrl_pkg::*;

module apb_op_ctrl #(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              apb_op,
  input  logic              apb_wr,
  input  logic [ADDR_W-1:0] ra,
  input  logic [ADDR_W-1:0] rb_or_imm,
  input  logic [DATA_W-1:0] st_data,
  output logic              stall,
  output logic              done,
  output logic [DATA_W-1:0] rdata_out,
  output logic              err,
  output logic [ADDR_W-1:0] paddr,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  apb_state_t state, state_nxt;
  logic       timeout;

`ifdef APB_TIMEOUT_EN
  apb_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (state == SETUP),
    .inc     ((state == ACCESS) && !pready),
    .expired (timeout)
  );
`else
  logic [7:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 8'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    psel      = 1'b0;
    penable   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (apb_op) state_nxt = SETUP;
      end
      SETUP: begin
        psel      = 1'b1;
        state_nxt = ACCESS;
      end
      ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (pready || timeout) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Holding stall low only in DONE lets the instruction retire exactly once.
  assign stall = apb_op && (state != DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paddr     <= '0;
      pwrite    <= 1'b0;
      pwdata    <= '0;
      rdata_out <= '0;
      err       <= 1'b0;
    end else begin
      if ((state == IDLE) && apb_op) begin
        paddr  <= ra + rb_or_imm;
        pwrite <= apb_wr;
        pwdata <= apb_wr ? st_data : '0;
      end
      // pready wins over a timeout landing in the same cycle.
      if ((state == ACCESS) && pready) begin
        if (!pwrite) rdata_out <= prdata;
        err <= pslverr;
      end else if ((state == ACCESS) && timeout) begin
        err <= 1'b1;
      end else if (state == DONE) begin
        err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_op_ctrl.sv
// Randomized self-checking bench for apb_op_ctrl against a cycle-count/transaction reference model.
module tb_apb_op_ctrl;

  logic       clk = 1'b0;
  logic       rst, apb_op, apb_wr, pready, pslverr;
  logic [7:0] ra, rb_or_imm, st_data, prdata;
  logic       stall, done, err, psel, penable, pwrite;
  logic [7:0] rdata_out, paddr, pwdata;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_rdata = 8'h00;

  typedef struct {
    int         done_cyc;
    int         psel_n;
    int         pen_n;
    int         stall_n;
    logic       stall_done;
    logic       err_done;
    logic [7:0] rd_done;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       wr;
    logic       stable;
    logic       err_after;
    logic       last_psel;
    logic       last_pen;
  } obs_t;

  always #5 clk = ~clk;

  apb_op_ctrl #(.ADDR_W(8), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .apb_op(apb_op), .apb_wr(apb_wr), .ra(ra),
    .rb_or_imm(rb_or_imm), .st_data(st_data), .stall(stall), .done(done),
    .rdata_out(rdata_out), .err(err), .paddr(paddr), .psel(psel),
    .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  // Runs one request; pready rises on the (waits+1)th ACCESS cycle. Operands scramble after cycle 1.
  task automatic do_op(input logic wr, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] sd, input int waits, input logic [7:0] prd,
                       input logic slv, input int budget, output obs_t o);
    o = '{done_cyc: -1, psel_n: 0, pen_n: 0, stall_n: 0, stall_done: 1'b1, err_done: 1'b0,
          rd_done: 8'h00, addr: 8'h00, wdata: 8'h00, wr: 1'b0, stable: 1'b1,
          err_after: 1'b1, last_psel: 1'b0, last_pen: 1'b0};
    apb_op = 1'b1; apb_wr = wr; ra = a; rb_or_imm = b; st_data = sd;
    for (int c = 1; c <= budget; c++) begin
      if (c > 1) begin
        ra = 8'($urandom); rb_or_imm = 8'($urandom); st_data = 8'($urandom); apb_wr = 1'($urandom);
      end
      pready  = (c == 3 + waits);
      prdata  = pready ? prd : 8'($urandom);
      pslverr = pready ? slv : 1'($urandom);
      #1;
      if (stall) o.stall_n++;
      if (psel) begin
        if (o.psel_n == 0) begin o.addr = paddr; o.wdata = pwdata; o.wr = pwrite; end
        else if (paddr !== o.addr || pwdata !== o.wdata || pwrite !== o.wr) o.stable = 1'b0;
        o.psel_n++;
      end
      if (penable) o.pen_n++;
      o.last_psel = psel; o.last_pen = penable;
      if (done) begin
        o.done_cyc = c; o.stall_done = stall; o.err_done = err; o.rd_done = rdata_out;
      end
      @(posedge clk); @(negedge clk);
      if (o.done_cyc > 0) break;
    end
    apb_op = 1'b0; pready = 1'b0; pslverr = 1'b0;
    #1 o.err_after = err;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; apb_op = 1'b0; apb_wr = 1'b0; ra = 8'h00; rb_or_imm = 8'h00;
    st_data = 8'h00; prdata = 8'h00; pready = 1'b0; pslverr = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++; if ({psel, penable, pwrite, done, err, stall} !== 6'b0) begin n_bad++;
      $display("FAIL reset_ctrl: got %b want 000000", {psel, penable, pwrite, done, err, stall}); end
    n_vec++; if ({paddr, pwdata, rdata_out} !== 24'h0) begin n_bad++;
      $display("FAIL reset_data: got %h want 000000", {paddr, pwdata, rdata_out}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero_wait_write();
    obs_t o;
    do_op(1'b1, 8'h10, 8'h04, 8'hA5, 0, 8'h00, 1'b0, 20, o);
    n_vec++; if (o.addr !== 8'h14 || o.wdata !== 8'hA5 || o.wr !== 1'b1) begin n_bad++;
      $display("FAIL zw_bus: got addr=%h wdata=%h wr=%b want 14 a5 1", o.addr, o.wdata, o.wr); end
    n_vec++; if (o.psel_n !== 2 || o.pen_n !== 1 || o.done_cyc !== 4) begin n_bad++;
      $display("FAIL zw_timing: got psel=%0d pen=%0d done@%0d want 2 1 4", o.psel_n, o.pen_n, o.done_cyc); end
    n_vec++; if (o.stall_done !== 1'b0 || o.stall_n !== 3 || o.err_done !== 1'b0) begin n_bad++;
      $display("FAIL zw_stall: got stall_done=%b stall_n=%0d err=%b want 0 3 0", o.stall_done, o.stall_n, o.err_done); end
  endtask

  task automatic test_read_waits();
    obs_t o;
    do_op(1'b0, 8'h22, 8'h01, 8'hFF, 3, 8'h3C, 1'b0, 30, o);
    exp_rdata = 8'h3C;
    n_vec++; if (o.done_cyc !== 7 || o.pen_n !== 4 || o.stall_n !== 6) begin n_bad++;
      $display("FAIL rw_timing: got done@%0d pen=%0d stall_n=%0d want 7 4 6", o.done_cyc, o.pen_n, o.stall_n); end
    n_vec++; if (o.rd_done !== 8'h3C || o.wdata !== 8'h00 || o.addr !== 8'h23 || !o.stable) begin n_bad++;
      $display("FAIL rw_data: got rd=%h wd=%h addr=%h stable=%b want 3c 00 23 1", o.rd_done, o.wdata, o.addr, o.stable); end
  endtask

  task automatic test_slverr_wrap();
    obs_t o;
    do_op(1'b1, 8'hF0, 8'h20, 8'h5A, 1, 8'h00, 1'b1, 20, o);
    n_vec++; if (o.addr !== 8'h10) begin n_bad++;
      $display("FAIL wrap_addr: got %h want 10", o.addr); end
    n_vec++; if (o.err_done !== 1'b1 || o.err_after !== 1'b0) begin n_bad++;
      $display("FAIL slverr: got done_err=%b after=%b want 1 0", o.err_done, o.err_after); end
    n_vec++; if (o.rd_done !== exp_rdata) begin n_bad++;
      $display("FAIL wr_keeps_rdata: got %h want %h", o.rd_done, exp_rdata); end
  endtask

  task automatic test_random_ops();
    obs_t o;
    logic wr, slv; logic [7:0] a, b, sd, prd; int w;
    for (int i = 0; i < 24; i++) begin
      wr = 1'($urandom); slv = 1'($urandom); a = 8'($urandom); b = 8'($urandom);
      sd = 8'($urandom); prd = 8'($urandom); w = $urandom_range(0, 4);
      do_op(wr, a, b, sd, w, prd, slv, 30, o);
      if (!wr) exp_rdata = prd;
      n_vec++; if (o.addr !== 8'((int'(a) + int'(b)) % 256) || o.wdata !== (wr ? sd : 8'h00) || o.wr !== wr) begin n_bad++;
        $display("FAIL rnd_bus[%0d]: got addr=%h wd=%h wr=%b", i, o.addr, o.wdata, o.wr); end
      n_vec++; if (o.done_cyc !== 4 + w || o.stall_n !== 3 + w || !o.stable) begin n_bad++;
        $display("FAIL rnd_timing[%0d]: got done@%0d stall_n=%0d stable=%b want %0d", i, o.done_cyc, o.stall_n, o.stable, 4 + w); end
      n_vec++; if (o.rd_done !== exp_rdata || o.err_done !== slv || o.err_after !== 1'b0) begin n_bad++;
        $display("FAIL rnd_result[%0d]: got rd=%h err=%b after=%b want %h %b 0", i, o.rd_done, o.err_done, o.err_after, exp_rdata, slv); end
    end
  endtask

  task automatic test_back_to_back();
    int dones = 0; int gap = 0; int max_gap = 0; int transfers = 0;
    logic prev_psel = 1'b0; logic [7:0] addrs [2];
    apb_op = 1'b1; apb_wr = 1'b0; pready = 1'b1; pslverr = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      ra = (c < 5) ? 8'h40 : 8'h80; rb_or_imm = 8'h02; prdata = 8'(c);
      #1;
      if (done) dones++;
      if (!psel && prev_psel) gap = 0;
      if (!psel) gap++;
      if (psel && !prev_psel) begin
        if (transfers > 0 && gap > max_gap) max_gap = gap;
        if (transfers < 2) addrs[transfers] = paddr;
        transfers++;
      end
      prev_psel = psel;
      @(posedge clk); @(negedge clk);
    end
    apb_op = 1'b0; pready = 1'b0;
    exp_rdata = 8'h07;
    @(negedge clk);
    n_vec++; if (dones !== 2 || transfers !== 2 || max_gap < 1) begin n_bad++;
      $display("FAIL b2b: got dones=%0d xfers=%0d gap=%0d want 2 2 >=1", dones, transfers, max_gap); end
    n_vec++; if (addrs[0] !== 8'h42 || addrs[1] !== 8'h82 || rdata_out !== exp_rdata) begin n_bad++;
      $display("FAIL b2b_data: got %h %h rd=%h want 42 82 %h", addrs[0], addrs[1], rdata_out, exp_rdata); end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    apb_op = 1'b1; apb_wr = 1'b1; ra = 8'h01; rb_or_imm = 8'h01; st_data = 8'h99; pready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if ({psel, penable} !== 2'b11) begin n_bad++;
      $display("FAIL rst_mid_pre: got %b want 11", {psel, penable}); end
    #1 rst = 1'b1;
    #1;
    n_vec++; if ({psel, penable, done, paddr} !== 11'h0) begin n_bad++;
      $display("FAIL rst_mid: got sel=%b en=%b done=%b addr=%h want 0", psel, penable, done, paddr); end
    apb_op = 1'b0;
    @(negedge clk); rst = 1'b0; exp_rdata = 8'h00;
    @(negedge clk);
    do_op(1'b0, 8'h30, 8'h03, 8'h00, 0, 8'hC3, 1'b0, 20, o);
    exp_rdata = 8'hC3;
    n_vec++; if (o.done_cyc !== 4 || o.rd_done !== 8'hC3 || o.addr !== 8'h33) begin n_bad++;
      $display("FAIL rst_recover: got done@%0d rd=%h addr=%h want 4 c3 33", o.done_cyc, o.rd_done, o.addr); end
  endtask

  task automatic test_stuck_ready();
    obs_t o;
`ifdef APB_TIMEOUT_EN
    do_op(1'b0, 8'h05, 8'h05, 8'h00, 100000, 8'hEE, 1'b0, 60, o);
    n_vec++; if (o.done_cyc !== 19 || o.pen_n !== 16 || o.err_done !== 1'b1 || o.rd_done !== exp_rdata) begin n_bad++;
      $display("FAIL timeout: got done@%0d pen=%0d err=%b rd=%h want 19 16 1 %h", o.done_cyc, o.pen_n, o.err_done, o.rd_done, exp_rdata); end
`else
    do_op(1'b0, 8'h05, 8'h05, 8'h00, 100000, 8'hEE, 1'b0, 110, o);
    n_vec++; if (o.done_cyc !== -1 || o.last_psel !== 1'b1 || o.last_pen !== 1'b1 || o.pen_n !== 108) begin n_bad++;
      $display("FAIL no_timeout: got done@%0d sel=%b en=%b pen=%0d want -1 1 1 108", o.done_cyc, o.last_psel, o.last_pen, o.pen_n); end
    rst = 1'b1; @(negedge clk); rst = 1'b0; @(negedge clk);
`endif
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_zero_wait_write();
    test_read_waits();
    test_slverr_wrap();
    test_random_ops();
    test_back_to_back();
    test_reset_mid();
    test_stuck_ready();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
